// File: rtl/lbp_pkg.sv
// lbp_pkg: shared LBP constants and histogram FSM states
package lbp_pkg;
    localparam int LBP_CODE_W = 8;
    localparam int LBP_DATA_W = 9;
    localparam int LBP_NBINS  = 256;
    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_FLUSH,
        ST_DRAIN,
        ST_DONE
    } state_t;
endpackage

// File: rtl/hist_ram.sv
// hist_ram: LBP_NBINS x COUNT_W 1R1W RAM, synchronous read, read-during-write returns old data
// Ports: i_clk clock; i_we/i_waddr/i_wdata write port; i_raddr read address; o_rdata registered read data
module hist_ram
    import lbp_pkg::*;
#(
    parameter int COUNT_W = 14
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [LBP_CODE_W-1:0] i_waddr,
    input  logic [COUNT_W-1:0]    i_wdata,
    input  logic [LBP_CODE_W-1:0] i_raddr,
    output logic [COUNT_W-1:0]    o_rdata
);
    logic [COUNT_W-1:0] r_mem [LBP_NBINS];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/lbp_hist.sv
// lbp_hist: 256-bin histogram of LBP codes per frame, drained bin by bin over valid/ready
// Ports: i_clk; i_reset_n async active-low; i_lbp_valid/i_lbp_data/i_lbp_finish from the LBP engine;
//        i_hist_restart starts a new frame from DONE; i_hist_ready/o_hist_valid/o_hist_bin/o_hist_count drain port;
//        o_busy (CLEAR/DRAIN), o_done (DONE), o_err sticky drop/saturation flag.
// Macro LBP_HIST_SAT_EN: bins saturate at 2^COUNT_W-1 and flag err; otherwise they wrap silently.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int COUNT_W = 14
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_lbp_valid,
    input  logic [LBP_DATA_W-1:0] i_lbp_data,
    input  logic                  i_lbp_finish,
    input  logic                  i_hist_restart,
    input  logic                  i_hist_ready,
    output logic                  o_hist_valid,
    output logic [LBP_CODE_W-1:0] o_hist_bin,
    output logic [COUNT_W-1:0]    o_hist_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);
    state_t                r_state, w_next;
    logic [LBP_CODE_W-1:0] r_ptr, r_s1_code, r_wc, r_bin;
    logic [COUNT_W-1:0]    r_wd, w_rdata, w_base, w_inc, w_wdata;
    logic [LBP_CODE_W-1:0] w_waddr, w_raddr;
    logic                  r_s1_v, r_wv, r_fin_q, r_err, r_hv, r_busy, r_done;
    logic                  w_accept, w_drop, w_fin_rise, w_hs, w_we, w_sat;

    assign w_accept   = (r_state == ST_ACCUM) & i_lbp_valid & ~i_lbp_data[LBP_DATA_W-1];
    assign w_drop     = i_lbp_valid & ~w_accept;
    assign w_fin_rise = i_lbp_finish & ~r_fin_q;
    assign w_hs       = r_hv & i_hist_ready;
    // The RAM returns old data when the same bin was written last cycle, so take the in-flight value
    assign w_base     = (r_wv && r_wc == r_s1_code) ? r_wd : w_rdata;
`ifdef LBP_HIST_SAT_EN
    assign w_sat      = &w_base;
`else
    assign w_sat      = 1'b0;
`endif
    assign w_inc      = w_sat ? w_base : w_base + COUNT_W'(1);
    assign w_we       = (r_state == ST_CLEAR) | r_s1_v;
    assign w_waddr    = (r_state == ST_CLEAR) ? r_ptr : r_s1_code;
    assign w_wdata    = (r_state == ST_CLEAR) ? '0 : w_inc;
    assign w_raddr    = (r_state == ST_DRAIN) ? r_ptr : i_lbp_data[LBP_CODE_W-1:0];

    hist_ram #(.COUNT_W(COUNT_W)) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_ptr == '1) w_next = ST_ACCUM;
            ST_ACCUM: if (w_fin_rise) w_next = ST_FLUSH;
            ST_FLUSH: if (!r_s1_v) w_next = ST_DRAIN;
            ST_DRAIN: if (w_hs && r_bin == '1) w_next = ST_DONE;
            ST_DONE:  if (i_hist_restart) w_next = ST_CLEAR;
            default:  w_next = ST_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_CLEAR;
            r_ptr     <= '0;
            r_s1_v    <= 1'b0;
            r_s1_code <= '0;
            r_wv      <= 1'b0;
            r_wc      <= '0;
            r_wd      <= '0;
            r_fin_q   <= 1'b0;
            r_err     <= 1'b0;
            r_hv      <= 1'b0;
            r_bin     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == ST_CLEAR) || (w_next == ST_DRAIN);
            r_done  <= (w_next == ST_DONE);
            r_fin_q <= i_lbp_finish;
            r_s1_v  <= w_accept;
            if (w_accept) r_s1_code <= i_lbp_data[LBP_CODE_W-1:0];
            r_wv    <= r_s1_v;
            r_wc    <= r_s1_code;
            r_wd    <= w_inc;
            if (r_state == ST_DONE && i_hist_restart) r_err <= 1'b0;
            else if (w_drop || (r_s1_v && w_sat)) r_err <= 1'b1;
            // One pointer serves as clear address and drain address; it wraps to 0 after CLEAR and after bin 255
            if (r_state == ST_CLEAR || w_hs) r_ptr <= r_ptr + 1'b1;
            else if (r_state == ST_FLUSH) r_ptr <= '0;
            // RAM read is issued in the idle DRAIN cycle; its registered data is presented the next cycle
            if (r_state == ST_DRAIN && !r_hv) begin
                r_hv  <= 1'b1;
                r_bin <= r_ptr;
            end else if (w_hs) r_hv <= 1'b0;
        end
    end

    // Read address stays on r_ptr while a bin is offered, so the RAM output holds steady
    assign o_hist_valid = r_hv;
    assign o_hist_bin   = r_bin;
    assign o_hist_count = r_hv ? w_rdata : '0;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_err        = r_err;
endmodule
